// File: rtl/spart_tx_fifo.sv
// Transmit-byte buffer between the SPART byte select and the SPART transmitter.
// The head byte is held in a register so tx_data never passes wr_data through combinationally.
module spart_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              clr_ovf,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic              push;
  logic              pop;
  logic              drop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign tx_valid   = ~empty;
  assign pop        = tx_valid & tx_ready;
  assign push       = wr_en & (~full | pop);
  assign drop       = wr_en & full & ~pop;
  assign rd_ptr_nxt = rd_ptr + ONE_PTR;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ONE_PTR;
        end
        if (pop) begin
          rd_ptr <= rd_ptr_nxt;
        end
        if (push && !pop) begin
          count <= count + ONE_CNT;
        end else if (pop && !push) begin
          count <= count - ONE_CNT;
        end
        // Reload the head register; with one entry left the new head is the incoming byte.
        if (pop) begin
          if (count == ONE_CNT) begin
            if (push) begin
              tx_data <= wr_data;
            end
          end else begin
            tx_data <= mem[rd_ptr_nxt];
          end
        end else if (empty && push) begin
          tx_data <= wr_data;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Self-checking bench for spart_tx_fifo: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_spart_tx_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              clr_ovf;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic       m_ovf;

  spart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_ovf(clr_ovf), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // One clock with the given inputs; the model applies the FIFO rules to its queue.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic fl,
                       input logic co, input logic rdy);
    bit m_pop, m_full, m_push, m_drop;
    wr_en = we; wr_data = wd; flush = fl; clr_ovf = co; tx_ready = rdy;
    @(posedge clk);
    m_pop  = (mq.size() > 0) && rdy;
    m_full = (mq.size() == DEPTH);
    m_push = we && (!m_full || m_pop);
    m_drop = we && m_full && !m_pop;
    if (fl) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(wd);
    end
    if (m_drop) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
    #1;
    wr_en = 0; flush = 0; clr_ovf = 0; tx_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; wr_en = 0; wr_data = 0; flush = 0; clr_ovf = 0; tx_ready = 0;
    mq.delete(); m_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", tx_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    cycle(1, 8'hA5, 0, 0, 0);
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", tx_valid); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", tx_data); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    cycle(0, 8'h00, 0, 0, 1);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", empty); end
    cycle(0, 8'h00, 0, 0, 1);
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL empty_ready_count: got %0d want 0", count); end
  endtask

  task automatic test_full_overflow;
    for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 0, 0);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf: got %b want 0", overflow); end
    cycle(1, 8'h09, 0, 0, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_ovf: got %b want 1", overflow); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL drop_count: got %0d want 8", count); end
    n_cmp++; if (tx_data !== 8'h01) begin n_err++; $display("FAIL drop_data: got %h want 01", tx_data); end
    cycle(0, 8'h00, 0, 1, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", overflow); end
    cycle(1, 8'h0A, 0, 1, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_order [8];
    for (int i = 0; i < 7; i++) exp_order[i] = 8'(i + 2);
    exp_order[7] = 8'hFF;
    cycle(1, 8'hFF, 0, 0, 1);
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL pushpop_count: got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (tx_data !== exp_order[i] || tx_valid !== 1'b1) begin
        n_err++; $display("FAIL drain_%0d: got %h/%b want %h/1", i, tx_data, tx_valid, exp_order[i]);
      end
      cycle(0, 8'h00, 0, 0, 1);
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drain_ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_stall;
    for (int i = 1; i <= 3; i++) cycle(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'h00, 0, 0, 0);
      n_cmp++;
      if (tx_data !== 8'h01 || count !== 4'd3) begin
        n_err++; $display("FAIL stall_%0d: got %h/%0d want 01/3", i, tx_data, count);
      end
    end
  endtask

  task automatic test_flush;
    logic ovf_before;
    cycle(1, 8'h04, 0, 0, 0);
    ovf_before = m_ovf;
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL preflush_count: got %0d want 4", count); end
    cycle(1, 8'hAA, 1, 0, 1);
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", tx_valid); end
    n_cmp++; if (overflow !== ovf_before) begin n_err++; $display("FAIL flush_ovf: got %b want %b", overflow, ovf_before); end
    cycle(0, 8'h00, 0, 0, 0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_discard: got %b want 1", empty); end
    cycle(1, 8'h5C, 0, 1, 0);
    n_cmp++; if (tx_data !== 8'h5C || count !== 4'd1) begin
      n_err++; $display("FAIL postflush_push: got %h/%0d want 5c/1", tx_data, count);
    end
  endtask

  task automatic test_async_reset;
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    mq.delete(); m_ovf = 0;
    n_cmp++; if (count !== 4'd0 || tx_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++; $display("FAIL async_rst_state: got count %0d valid %b empty %b want 0/0/1", count, tx_valid, empty);
    end
    n_cmp++; if (tx_data !== 8'h00 || overflow !== 1'b0) begin
      n_err++; $display("FAIL async_rst_data: got %h/%b want 00/0", tx_data, overflow);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic we, fl, co, rdy;
    logic [7:0] wd;
    for (int i = 0; i < 10000; i++) begin
      // Alternate fill-biased and drain-biased phases so both full and empty are visited.
      if (((i / 500) % 2) == 0) begin
        we = ($urandom_range(0, 99) < 75); rdy = ($urandom_range(0, 99) < 30);
      end else begin
        we = ($urandom_range(0, 99) < 30); rdy = ($urandom_range(0, 99) < 75);
      end
      fl = ($urandom_range(0, 299) == 0);
      co = ($urandom_range(0, 49) == 0);
      wd = 8'($urandom);
      cycle(we, wd, fl, co, rdy);
      n_cmp++;
      if (tx_valid !== (mq.size() != 0) || count !== 4'(mq.size())
          || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)
          || overflow !== m_ovf || (mq.size() != 0 && tx_data !== mq[0])) begin
        n_err++;
        $display("FAIL random_%0d: got v%b d%h c%0d f%b e%b o%b want c%0d d%h o%b",
                 i, tx_valid, tx_data, count, full, empty, overflow,
                 mq.size(), (mq.size() != 0) ? mq[0] : 8'h00, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_full_push_pop();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
